nfc_atom_data_out: RTL and testbench
====================================

Name: nfc_atom_data_out

Overview:
- Data-out atomic generator (DOA): the ACG primitive that sits directly downstream of command FSMs such as Set Feature, Program Page and Write Buffer.
- Starts when its command bit is set while it is idle.
- Pulls 16-bit words over the ACG write stream and serialises them high byte first onto the 8-bit NAND DQ bus with timed WE# pulses.
- Reports idle on oReady and completion as a one-cycle oLastStep pulse.

Parameters:
- NumberOfWays, 4, number of chip-enable ways.
- CommandBit, 5, bit index of iCommand that starts this atom.
- WELowCycles, 2, cycles WE# is held low per byte (tWP); minimum 1.
- WEHighCycles, 2, cycles WE# is held high per byte (tWH/tDH); minimum 1.

Ports:
- iSystemClock  in  1  system clock.
- iReset  in  1  synchronous, active-high reset.
- iCommand  in  8  ACG command vector; only bit CommandBit is used.
- iTargetWay  in  NumberOfWays  active-low way select, latched at start.
- iNumOfData  in  16  number of bytes to transfer, latched at start.
- oReady  out  1  high when idle and able to accept a start.
- oLastStep  out  1  one-cycle completion pulse.
- iWriteData  in  16  write word; [15:8] is sent first.
- iWriteLast  in  1  upstream marks the final word.
- iWriteValid  in  1  write word is valid.
- oWriteReady  out  1  word is consumed this cycle.
- oError  out  1  sticky WriteLast/count mismatch flag; cleared on the next start.
- oChecksum  out  8  running XOR of bytes sent (see Optional Feature).
- oPO_DQ  out  8  NAND DQ output value.
- oPO_DQOE  out  1  DQ output enable.
- oPO_ChipEnable  out  NumberOfWays  CE#, active low.
- oPO_WriteEnable  out  1  WE#, active low.
- oPO_CLE  out  1  command latch enable, held 0.
- oPO_ALE  out  1  address latch enable, held 0.

Behaviour:
- Reset values: oReady=1, oLastStep=0, oWriteReady=0, oError=0, oChecksum=0, oPO_DQ=0, oPO_DQOE=0, oPO_ChipEnable=all 1s, oPO_WriteEnable=1, CLE=ALE=0.
- Reset is honoured mid-operation: the FSM returns to IDLE with all outputs at reset values; any half-sent byte is abandoned.
- States: IDLE, FETCH, HI_LOW, HI_HIGH, LO_LOW, LO_HIGH, DONE.
- IDLE:
  - On iCommand[CommandBit]=1, latch iTargetWay and iNumOfData, clear oError and the checksum, and drop oReady the next cycle.
  - If iNumOfData==0, go to DONE; otherwise go to FETCH.
- FETCH:
  - oWriteReady=iWriteValid; a transfer occurs when both are high.
  - On transfer, register the word, decrement the remaining byte count by 1, and go to HI_LOW.
  - With iWriteValid low, stay in FETCH with WE# high and CE# asserted.
- HI_LOW / HI_HIGH:
  - DQ=word[15:8], DQOE=1.
  - WE# low for WELowCycles, then high for WEHighCycles; the byte is latched by the NAND on WE# rising.
  - Leaving HI_HIGH:
    - remaining==0: go to DONE.
    - otherwise: decrement remaining and go to LO_LOW.
- LO_LOW / LO_HIGH:
  - Same timing with DQ=word[7:0].
  - Leaving LO_HIGH: go to DONE if remaining==0, else to FETCH.
- Odd byte count: the low byte of the final word is dropped, and that word is still consumed.
- DONE:
  - oLastStep=1 for exactly one cycle; DQOE=0; CE# deasserted.
  - Next state IDLE, with oReady=1 in the same cycle as oLastStep.
- Latency: with continuous iWriteValid, the first WE# falling edge occurs 2 cycles after the start cycle. Each byte takes WELowCycles+WEHighCycles cycles. Between words, FETCH adds one WE#-high cycle.
- CE# (oPO_ChipEnable) equals the latched way mask in every state except IDLE and DONE.
- WriteLast check:
  - oError=1 if a word with iWriteLast=1 is consumed while bytes remain after it.
  - oError=1 if the final word is consumed with iWriteLast=0.
  - Count governs the transfer length; the transfer is never truncated.
- A start request while not idle is ignored; iCommand is not re-sampled until IDLE.
- The remaining-byte counter is 16 bits; 16'hFFFF is legal and the counter never wraps.

Optional Feature:
- Macro NFC_DOA_CHECKSUM_EN.
- Defined: oChecksum is the XOR of all bytes driven (WE# rising), cleared at start and held after DONE.
- Undefined: checksum logic is absent and oChecksum is tied to 8'h00.

Decomposition:
- Shared package nfc_pkg:
  - ACG command bit indices (CA=6, DOA=5, DI=4).
  - Default timing counts.
  - The FSM state encoding localparams, one-hot, 7 bits.
- Sub-module nfc_we_pulse_timer: given start, WELowCycles and WEHighCycles, it produces WE# and a phase-done strobe. It is instantiated once.

Test Plan:
- Start with NumOfData=4, words 16'h1400 then 16'h0000 (WriteLast on the 2nd), valid held 1 -> DQ bytes 14,00,00,00 on 4 WE# rising edges; 2 oWriteReady pulses; oLastStep 1 cycle; oError=0; checksum 8'h14 with the macro defined.
- NumOfData=3, words 16'hA1B2 and 16'hC3D4 (last) -> DQ A1,B2,C3 only, 3 WE# pulses, 2 words consumed, D4 never driven.
- NumOfData=0 -> no WE# pulse, CE# stays high, oLastStep 2 cycles after start, oReady back to 1.
- NumOfData=4 with iWriteValid low for 5 cycles after the 1st word -> WE# held high and CE# asserted during the stall; the byte sequence is unchanged.
- WriteLast=1 on the 1st word of a 4-byte transfer -> all 4 bytes sent, oError=1 until the next start.
- iReset pulsed during LO_LOW -> the next cycle shows WE#=1, CE#=all 1s, DQOE=0, oReady=1, oLastStep never pulsed.

Source files
------------

// File: rtl/nfc_pkg.sv
// -----------------------------------------------------------------------------
// nfc_pkg
// Definitions shared by the NFC atomic command generators (ACG).
//   - ACG command vector bit indices (CA, DOA, DI)
//   - default WE# pulse timing counts
//   - one-hot state encoding of the data-out atom FSM
// No ports (package).
// -----------------------------------------------------------------------------
package nfc_pkg;

    // Bit positions inside the 8-bit ACG command vector
    localparam int unsigned CmdBitCA  = 6;
    localparam int unsigned CmdBitDOA = 5;
    localparam int unsigned CmdBitDI  = 4;

    // Default WE# timing in system clock cycles (tWP low, tWH/tDH high)
    localparam int unsigned DefaultWELowCycles  = 2;
    localparam int unsigned DefaultWEHighCycles = 2;

    // Data-out atom FSM states, one-hot
    localparam logic [6:0] StIdle   = 7'b000_0001;
    localparam logic [6:0] StFetch  = 7'b000_0010;
    localparam logic [6:0] StHiLow  = 7'b000_0100;
    localparam logic [6:0] StHiHigh = 7'b000_1000;
    localparam logic [6:0] StLoLow  = 7'b001_0000;
    localparam logic [6:0] StLoHigh = 7'b010_0000;
    localparam logic [6:0] StDone   = 7'b100_0000;

endpackage

// File: rtl/nfc_we_pulse_timer.sv
// -----------------------------------------------------------------------------
// nfc_we_pulse_timer
// Times the low and high halves of one WE# byte strobe.
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   lowPhase_i   FSM is in a WE#-low phase (start of a phase restarts the count)
//   highPhase_i  FSM is in a WE#-high phase
//   weN_o        WE#, active low
//   phaseDone_o  last cycle of the current low/high phase
// -----------------------------------------------------------------------------
module nfc_we_pulse_timer #(
    parameter int LowCycles  = 2,
    parameter int HighCycles = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic lowPhase_i,
    input  logic highPhase_i,
    output logic weN_o,
    output logic phaseDone_o
);

    localparam logic [15:0] LowLast  = 16'(LowCycles - 1);
    localparam logic [15:0] HighLast = 16'(HighCycles - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        limitHit;

    // A phase ends once the counter reaches its length minus one
    always_comb begin
        limitHit = 1'b0;
        if (lowPhase_i) begin
            limitHit = (cnt_q == LowLast);
        end else if (highPhase_i) begin
            limitHit = (cnt_q == HighLast);
        end
    end

    // Counter restarts at each phase boundary so the FSM never has to load it
    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (!(lowPhase_i || highPhase_i) || limitHit) begin
            cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign weN_o       = ~lowPhase_i;
    assign phaseDone_o = limitHit;

endmodule

// File: rtl/nfc_atom_data_out.sv
// -----------------------------------------------------------------------------
// nfc_atom_data_out
// Data-out atomic generator: fetches 16-bit words from the ACG write stream and
// drives them high byte first onto the NAND DQ bus with timed WE# pulses.
// Optional feature macro: NFC_DOA_CHECKSUM_EN (running XOR of bytes sent on
// oChecksum; when undefined oChecksum is tied to zero).
// Ports:
//   iSystemClock / iReset      clock, synchronous active-high reset
//   iCommand                   ACG command vector, bit CommandBit starts the atom
//   iTargetWay / iNumOfData    way mask (active low) and byte count, latched at start
//   oReady / oLastStep         idle indication, one-cycle completion pulse
//   iWriteData/Last/Valid      write stream word, last marker, valid
//   oWriteReady                word consumed this cycle
//   oError                     sticky WriteLast/count mismatch
//   oChecksum                  XOR of bytes driven
//   oPO_*                      NAND pad outputs (DQ, DQOE, CE#, WE#, CLE, ALE)
// -----------------------------------------------------------------------------
module nfc_atom_data_out
    import nfc_pkg::*;
#(
    parameter int NumberOfWays = 4,
    parameter int CommandBit   = 5,
    parameter int WELowCycles  = 2,
    parameter int WEHighCycles = 2
) (
    input  logic                    iSystemClock,
    input  logic                    iReset,
    input  logic [7:0]              iCommand,
    input  logic [NumberOfWays-1:0] iTargetWay,
    input  logic [15:0]             iNumOfData,
    output logic                    oReady,
    output logic                    oLastStep,
    input  logic [15:0]             iWriteData,
    input  logic                    iWriteLast,
    input  logic                    iWriteValid,
    output logic                    oWriteReady,
    output logic                    oError,
    output logic [7:0]              oChecksum,
    output logic [7:0]              oPO_DQ,
    output logic                    oPO_DQOE,
    output logic [NumberOfWays-1:0] oPO_ChipEnable,
    output logic                    oPO_WriteEnable,
    output logic                    oPO_CLE,
    output logic                    oPO_ALE
);

    logic [6:0]              state_q, state_d;
    logic [NumberOfWays-1:0] way_q, way_d;
    logic [15:0]             remain_q, remain_d;
    logic [15:0]             word_q, word_d;
    logic                    error_q, error_d;
    logic                    writeReady;
    logic                    startAccept;
    logic                    hiPhase, loPhase;
    logic                    phaseDone;
    logic                    unusedCmd;

    assign unusedCmd   = ^iCommand;
    assign startAccept = (state_q == StIdle) && iCommand[CommandBit];
    assign hiPhase     = (state_q == StHiLow) || (state_q == StHiHigh);
    assign loPhase     = (state_q == StLoLow) || (state_q == StLoHigh);

    nfc_we_pulse_timer #(
        .LowCycles  (WELowCycles),
        .HighCycles (WEHighCycles)
    ) u_weTimer (
        .clk_i       (iSystemClock),
        .rst_i       (iReset),
        .lowPhase_i  ((state_q == StHiLow) || (state_q == StLoLow)),
        .highPhase_i ((state_q == StHiHigh) || (state_q == StLoHigh)),
        .weN_o       (oPO_WriteEnable),
        .phaseDone_o (phaseDone)
    );

    // Next-state logic. remain counts bytes not yet claimed by a phase; it is
    // decremented when the high byte is claimed (FETCH) and when the low byte
    // is claimed (leaving HI_HIGH), so it only decrements while non-zero.
    // A word is the final one when at most two bytes remain as it is fetched.
    always_comb begin
        state_d    = state_q;
        way_d      = way_q;
        remain_d   = remain_q;
        word_d     = word_q;
        error_d    = error_q;
        writeReady = 1'b0;
        case (state_q)
            StIdle: begin
                if (iCommand[CommandBit]) begin
                    way_d    = iTargetWay;
                    remain_d = iNumOfData;
                    error_d  = 1'b0;
                    state_d  = (iNumOfData == 16'd0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                writeReady = iWriteValid;
                if (iWriteValid) begin
                    word_d   = iWriteData;
                    remain_d = remain_q - 16'd1;
                    if ((iWriteLast && (remain_q > 16'd2)) ||
                        (!iWriteLast && (remain_q <= 16'd2))) begin
                        error_d = 1'b1;
                    end
                    state_d = StHiLow;
                end
            end
            StHiLow: begin
                if (phaseDone) state_d = StHiHigh;
            end
            StHiHigh: begin
                if (phaseDone) begin
                    if (remain_q == 16'd0) begin
                        state_d = StDone;
                    end else begin
                        remain_d = remain_q - 16'd1;
                        state_d  = StLoLow;
                    end
                end
            end
            StLoLow: begin
                if (phaseDone) state_d = StLoHigh;
            end
            StLoHigh: begin
                if (phaseDone) state_d = (remain_q == 16'd0) ? StDone : StFetch;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            state_q  <= StIdle;
            way_q    <= '1;
            remain_q <= 16'd0;
            word_q   <= 16'd0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            way_q    <= way_d;
            remain_q <= remain_d;
            word_q   <= word_d;
            error_q  <= error_d;
        end
    end

`ifdef NFC_DOA_CHECKSUM_EN
    logic [7:0] checksum_q, checksum_d;

    // A byte counts as driven on the WE# rising edge, i.e. at the end of its low phase
    always_comb begin
        checksum_d = checksum_q;
        if (startAccept) begin
            checksum_d = 8'h00;
        end else if (phaseDone && (state_q == StHiLow)) begin
            checksum_d = checksum_q ^ word_q[15:8];
        end else if (phaseDone && (state_q == StLoLow)) begin
            checksum_d = checksum_q ^ word_q[7:0];
        end
    end

    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            checksum_q <= 8'h00;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign oChecksum = checksum_q;
`else
    assign oChecksum = 8'h00;
`endif

    // oReady stays high in DONE so it coincides with oLastStep
    assign oReady         = (state_q == StIdle) || (state_q == StDone);
    assign oLastStep      = (state_q == StDone);
    assign oWriteReady    = writeReady;
    assign oError         = error_q;
    assign oPO_DQ         = hiPhase ? word_q[15:8] : (loPhase ? word_q[7:0] : 8'h00);
    assign oPO_DQOE       = hiPhase || loPhase;
    assign oPO_ChipEnable = ((state_q == StIdle) || (state_q == StDone)) ? '1 : way_q;
    assign oPO_CLE        = 1'b0;
    assign oPO_ALE        = 1'b0;

endmodule

// File: tb/tb_nfc_atom_data_out.sv
// -----------------------------------------------------------------------------
// tb_nfc_atom_data_out
// Self-checking bench for nfc_atom_data_out: directed scenarios followed by
// randomized transfers, compared against a byte-level reference model.
// -----------------------------------------------------------------------------
module tb_nfc_atom_data_out;

    localparam int NW  = 4;
    localparam int CB  = 5;
    localparam int WEL = 2;
    localparam int WEH = 2;

    logic          clock = 1'b0;
    logic          iReset;
    logic [7:0]    iCommand;
    logic [NW-1:0] iTargetWay;
    logic [15:0]   iNumOfData;
    logic          oReady, oLastStep;
    logic [15:0]   iWriteData;
    logic          iWriteLast, iWriteValid;
    logic          oWriteReady, oError;
    logic [7:0]    oChecksum, oPO_DQ;
    logic          oPO_DQOE;
    logic [NW-1:0] oPO_ChipEnable;
    logic          oPO_WriteEnable, oPO_CLE, oPO_ALE;

    int checks = 0;
    int errors = 0;

    logic [15:0] wordMem [16];
    logic        lastMem [16];

    always #5 clock = ~clock;

    nfc_atom_data_out #(
        .NumberOfWays (NW),
        .CommandBit   (CB),
        .WELowCycles  (WEL),
        .WEHighCycles (WEH)
    ) dut (
        .iSystemClock    (clock),
        .iReset          (iReset),
        .iCommand        (iCommand),
        .iTargetWay      (iTargetWay),
        .iNumOfData      (iNumOfData),
        .oReady          (oReady),
        .oLastStep       (oLastStep),
        .iWriteData      (iWriteData),
        .iWriteLast      (iWriteLast),
        .iWriteValid     (iWriteValid),
        .oWriteReady     (oWriteReady),
        .oError          (oError),
        .oChecksum       (oChecksum),
        .oPO_DQ          (oPO_DQ),
        .oPO_DQOE        (oPO_DQOE),
        .oPO_ChipEnable  (oPO_ChipEnable),
        .oPO_WriteEnable (oPO_WriteEnable),
        .oPO_CLE         (oPO_CLE),
        .oPO_ALE         (oPO_ALE)
    );

    // One comparison: counts it, and on mismatch counts and reports the failure
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checksum the DUT should show for a given XOR of driven bytes
    function automatic logic [7:0] sumView(input logic [7:0] s);
`ifdef NFC_DOA_CHECKSUM_EN
        return s;
`else
        return 8'h00 & s;
`endif
    endfunction

    // Runs one transfer of n bytes from wordMem/lastMem.
    // stallMode: 0 valid always high, 1 random valid gaps, 2 long gap after word 0.
    // resetAt >= 0 pulses iReset after that many WE# falling edges.
    task automatic applyStimulus(input int n, input int stallMode, input bit noise,
                                 input int resetAt, input logic [NW-1:0] way);
        logic [7:0]  expBytes[$];
        logic [7:0]  gotBytes[$];
        logic [15:0] w;
        logic [7:0]  expSum;
        int  expWords, cycle, idx, rises, falls, lowRun, firstFall;
        int  lastSeen, lastCycle, stallCnt, rs, post;
        bit  expErr, done, prevWe, prevReady, valid, ceEverLow, we, isFall;

        // Reference model: bytes in order, high byte first, truncated to n
        expWords = (n + 1) / 2;
        expSum   = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = wordMem[i / 2];
            expBytes.push_back((i % 2 == 0) ? w[15:8] : w[7:0]);
            expSum = expSum ^ expBytes[i];
        end
        expErr = 1'b0;
        for (int k = 0; k < expWords; k++) begin
            if (lastMem[k] && (n - 2 * (k + 1) > 0)) expErr = 1'b1;
            if ((k == expWords - 1) && !lastMem[k]) expErr = 1'b1;
        end

        @(negedge clock);
        iCommand     = 8'h00;
        iCommand[CB] = 1'b1;
        iTargetWay   = way;
        iNumOfData   = 16'(n);
        iWriteValid  = 1'b0;
        #1;
        checkOutput("readyAtStart", 32'(oReady), 1);

        cycle = 0; idx = 0; rises = 0; falls = 0; lowRun = 0; firstFall = -1;
        lastSeen = 0; lastCycle = -1; stallCnt = 0; rs = 0; post = 0;
        done = 0; prevWe = 1; prevReady = 1; ceEverLow = 0;

        while (!done && cycle < 2000) begin
            @(negedge clock);
            cycle++;
            if (rs == 1) begin
                iReset = 1'b1;
                rs = 2;
            end else if (rs == 2) begin
                iReset = 1'b0;
                rs = 3;
            end
            iCommand = 8'h00;
            if (noise && !prevReady && $urandom_range(0, 1) == 1) iCommand = 8'hFF;
            valid = 1'b1;
            if (stallMode == 2 && idx == 1 && stallCnt < 12) begin
                valid = 1'b0;
                stallCnt++;
            end else if (stallMode == 1 && $urandom_range(0, 3) == 0) begin
                valid = 1'b0;
            end
            iWriteValid = valid;
            iWriteData  = valid ? wordMem[idx % 16] : 16'($urandom);
            iWriteLast  = valid ? lastMem[idx % 16] : 1'($urandom);
            #1;

            if (cycle == 1) begin
                checkOutput("errorClearedAtStart", 32'(oError), 0);
                checkOutput("sumClearedAtStart", 32'(oChecksum), 0);
                checkOutput("readyAfterStart", 32'(oReady), (n == 0) ? 1 : 0);
            end
            if (rs == 3 && post == 0) begin
                checkOutput("rstWe", 32'(oPO_WriteEnable), 1);
                checkOutput("rstCe", 32'(oPO_ChipEnable), 32'({NW{1'b1}}));
                checkOutput("rstDqoe", 32'(oPO_DQOE), 0);
                checkOutput("rstReady", 32'(oReady), 1);
                checkOutput("rstWriteReady", 32'(oWriteReady), 0);
            end
            if (oPO_ChipEnable != {NW{1'b1}}) ceEverLow = 1;

            // Between words (all fetched bytes sent, next word not yet taken)
            // WE# must stay high while CE# stays on the target way
            if (rs == 0 && idx > 0 && idx < expWords && rises == 2 * idx && !oLastStep) begin
                checkOutput("gapWeHigh", 32'(oPO_WriteEnable), 1);
                checkOutput("gapCe", 32'(oPO_ChipEnable), 32'(way));
            end

            we = oPO_WriteEnable;
            isFall = (we == 0) && (prevWe == 1);
            if (isFall) begin
                falls++;
                if (falls == 1) firstFall = cycle;
                lowRun = 0;
            end
            if (we == 0) lowRun++;
            if (we == 1 && prevWe == 0 && rs == 0) begin
                rises++;
                gotBytes.push_back(oPO_DQ);
                checkOutput("dqoeAtRise", 32'(oPO_DQOE), 1);
                checkOutput("ceAtRise", 32'(oPO_ChipEnable), 32'(way));
                checkOutput("weLowWidth", lowRun, WEL);
            end
            if (oWriteReady && iWriteValid) idx++;

            if (oLastStep) begin
                lastSeen++;
                lastCycle = cycle;
                checkOutput("readyWithLast", 32'(oReady), 1);
                checkOutput("ceOffAtLast", 32'(oPO_ChipEnable), 32'({NW{1'b1}}));
                checkOutput("dqoeOffAtLast", 32'(oPO_DQOE), 0);
            end else if (lastSeen > 0) begin
                checkOutput("lastStepWidth", lastSeen, 1);
                checkOutput("readyAfterLast", 32'(oReady), 1);
                done = 1;
            end
            if (rs == 3) begin
                post++;
                if (post >= 20) done = 1;
            end
            if (resetAt >= 0 && rs == 0 && falls == resetAt && isFall) rs = 1;
            prevWe    = we;
            prevReady = oReady;
        end

        checkOutput("finishedInTime", 32'(done), 1);
        if (resetAt >= 0) begin
            checkOutput("noLastAfterReset", lastSeen, 0);
            checkOutput("resetErrorClear", 32'(oError), 0);
        end else begin
            checkOutput("byteCount", gotBytes.size(), n);
            for (int i = 0; i < n && i < gotBytes.size(); i++) begin
                checkOutput($sformatf("byte%0d", i), 32'(gotBytes[i]), 32'(expBytes[i]));
            end
            checkOutput("wordsConsumed", idx, expWords);
            checkOutput("errorFlag", 32'(oError), 32'(expErr));
            checkOutput("checksum", 32'(oChecksum), 32'(sumView(expSum)));
            checkOutput("cleAle", 32'({oPO_CLE, oPO_ALE}), 0);
            if (n == 0) begin
                checkOutput("zeroLenNoWe", falls, 0);
                checkOutput("zeroLenCeHigh", 32'(ceEverLow), 0);
                checkOutput("zeroLenLatency", 32'(lastCycle >= 1 && lastCycle <= 2), 1);
            end else if (stallMode == 0) begin
                checkOutput("firstFallLatency", firstFall, 2);
            end
            // Error and checksum hold while idle
            repeat (3) begin
                @(negedge clock);
                iCommand    = 8'h00;
                iWriteValid = 1'b0;
            end
            #1;
            checkOutput("errorSticky", 32'(oError), 32'(expErr));
            checkOutput("checksumHeld", 32'(oChecksum), 32'(sumView(expSum)));
            checkOutput("idleReady", 32'(oReady), 1);
        end
    endtask

    task automatic clearWords();
        for (int i = 0; i < 16; i++) begin
            wordMem[i] = 16'($urandom);
            lastMem[i] = 1'b0;
        end
    endtask

    initial begin
        int n;
        int nw;
        $display("[TB] start");
        iReset = 1'b1; iCommand = 8'h00; iTargetWay = '1; iNumOfData = 16'd0;
        iWriteData = 16'd0; iWriteLast = 1'b0; iWriteValid = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checkOutput("resetReady", 32'(oReady), 1);
        checkOutput("resetLast", 32'(oLastStep), 0);
        checkOutput("resetWriteReady", 32'(oWriteReady), 0);
        checkOutput("resetError", 32'(oError), 0);
        checkOutput("resetSum", 32'(oChecksum), 0);
        checkOutput("resetDq", 32'(oPO_DQ), 0);
        checkOutput("resetDqoe", 32'(oPO_DQOE), 0);
        checkOutput("resetCe", 32'(oPO_ChipEnable), 32'({NW{1'b1}}));
        checkOutput("resetWe", 32'(oPO_WriteEnable), 1);
        checkOutput("resetCleAle", 32'({oPO_CLE, oPO_ALE}), 0);
        @(negedge clock);
        iReset = 1'b0;

        // Four bytes, two words, last marked correctly
        clearWords();
        wordMem[0] = 16'h1400; wordMem[1] = 16'h0000; lastMem[1] = 1'b1;
        applyStimulus(4, 0, 0, -1, 4'b1110);

        // Odd count: low byte of the second word is dropped
        clearWords();
        wordMem[0] = 16'hA1B2; wordMem[1] = 16'hC3D4; lastMem[1] = 1'b1;
        applyStimulus(3, 0, 0, -1, 4'b1101);

        // Zero-length transfer
        clearWords();
        applyStimulus(0, 0, 0, -1, 4'b1011);

        // Long valid gap after the first word
        clearWords();
        wordMem[0] = 16'h1234; wordMem[1] = 16'h5678; lastMem[1] = 1'b1;
        applyStimulus(4, 2, 0, -1, 4'b0111);

        // WriteLast too early: error raised, all bytes still sent
        clearWords();
        wordMem[0] = 16'hDEAD; wordMem[1] = 16'hBEEF; lastMem[0] = 1'b1; lastMem[1] = 1'b1;
        applyStimulus(4, 0, 0, -1, 4'b1110);

        // Reset during the low byte's WE# low phase, then a clean transfer
        clearWords();
        wordMem[0] = 16'h55AA; wordMem[1] = 16'h0FF0; lastMem[1] = 1'b1;
        applyStimulus(4, 0, 0, 2, 4'b1101);
        applyStimulus(4, 0, 0, -1, 4'b1101);

        // Randomized transfers with gaps, busy-time start requests and mixed WriteLast
        for (int t = 0; t < 20; t++) begin
            clearWords();
            n  = $urandom_range(0, 12);
            nw = (n + 1) / 2;
            for (int k = 0; k < nw; k++) begin
                if ($urandom_range(0, 3) == 0) lastMem[k] = 1'($urandom);
                else lastMem[k] = (k == nw - 1);
            end
            for (int k = nw; k < 16; k++) lastMem[k] = 1'($urandom);
            applyStimulus(n, $urandom_range(0, 1), 1'($urandom),
                          -1, ~(4'b0001 << $urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
